// File: rtl/step_ctrl.sv
// Clock-enable generator for the processor core: debounced push-button bursts in step mode,
// fixed-rate enables in run mode, with halt and a free-running count of issued enables.
module step_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned RUN_DIV         = 4,
    parameter int unsigned BURST_W         = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               step_btn,
    input  logic               clk_select,
    input  logic [BURST_W-1:0] burst_len,
    input  logic               halt,
    output logic               cpu_en,
    output logic               busy,
    output logic [15:0]        step_count
);

    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned DivW = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
    localparam logic [CntW-1:0] DebLast = CntW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DivW-1:0] DivLast = DivW'(RUN_DIV - 1);

    typedef enum logic [1:0] {
        StIdle,
        StPress,
        StBurst,
        StRelease
    } state_e;

    state_e             state_q;
    logic               sync1_q;
    logic               s_q;
    logic               sel_q;
    logic               armed_q;
    logic [1:0]         warm_q;
    logic [CntW-1:0]    deb_q;
    logic [BURST_W-1:0] burst_q;
    logic [DivW-1:0]    div_q;
    logic               cpu_en_q;
    logic               busy_q;
    logic [15:0]        count_q;

    logic               mode_chg;
    logic [BURST_W-1:0] burst_load;

    assign mode_chg   = (clk_select != sel_q);
    assign burst_load = (burst_len == '0) ? BURST_W'(1) : burst_len;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            sync1_q  <= 1'b0;
            s_q      <= 1'b0;
            sel_q    <= 1'b0;
            armed_q  <= 1'b0;
            warm_q   <= 2'd0;
            deb_q    <= '0;
            burst_q  <= '0;
            div_q    <= '0;
            cpu_en_q <= 1'b0;
            busy_q   <= 1'b0;
            count_q  <= 16'd0;
        end else begin
            sync1_q <= step_btn;
            s_q     <= sync1_q;
            sel_q   <= clk_select;
            if (cpu_en_q) begin
                count_q <= count_q + 16'd1;
            end
            // A button still held through reset must be seen released before it can step again;
            // the synchronizer output is only trusted once it has refilled after reset.
            if (warm_q != 2'd2) begin
                warm_q <= warm_q + 2'd1;
            end else if (!s_q) begin
                armed_q <= 1'b1;
            end

            cpu_en_q <= 1'b0;
            busy_q   <= 1'b0;

            if (mode_chg) begin
                state_q <= StIdle;
                div_q   <= '0;
                deb_q   <= '0;
            end else if (clk_select) begin
                state_q  <= StIdle;
                div_q    <= (div_q == DivLast) ? '0 : div_q + 1'b1;
                cpu_en_q <= (div_q == DivLast) && !halt;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (s_q && armed_q) begin
                            state_q <= StPress;
                            deb_q   <= '0;
                        end
                    end
                    StPress: begin
                        if (!s_q) begin
                            state_q <= StIdle;
                        end else if (deb_q == DebLast) begin
                            burst_q <= burst_load;
                            deb_q   <= '0;
                            if (halt) begin
                                state_q <= StRelease;
                            end else begin
                                state_q  <= StBurst;
                                cpu_en_q <= 1'b1;
                                busy_q   <= 1'b1;
                            end
                        end else begin
                            deb_q <= deb_q + 1'b1;
                        end
                    end
                    StBurst: begin
                        if (halt || burst_q == BURST_W'(1)) begin
                            state_q <= StRelease;
                            deb_q   <= '0;
                        end else begin
                            burst_q  <= burst_q - 1'b1;
                            cpu_en_q <= 1'b1;
                            busy_q   <= 1'b1;
                        end
                    end
                    StRelease: begin
                        if (s_q) begin
                            deb_q <= '0;
                        end else if (deb_q == DebLast) begin
                            state_q <= StIdle;
                        end else begin
                            deb_q <= deb_q + 1'b1;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign cpu_en     = cpu_en_q;
    assign busy       = busy_q;
    assign step_count = count_q;

endmodule

// File: tb/tb_step_ctrl.sv
// Directed bench for step_ctrl: step bursts, bounce rejection, run rate, halt, mode switch,
// reset mid-burst, and step_count wrap on a second instance with RUN_DIV=1.
module tb_step_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        step_btn;
    logic        clk_select;
    logic [7:0]  burst_len;
    logic        halt;
    logic        cpu_en;
    logic        busy;
    logic [15:0] step_count;

    logic        w_rst;
    logic        w_sel;
    logic        w_en;
    logic        w_busy;
    logic [15:0] w_count;

    int errors = 0;
    int checks = 0;

    // Per-window observations, index t counts rising edges since clr_mon.
    int t, en_cnt, en_first, en_last, busy_cnt, busy_bad, gap_min, gap_max;

    always #5 clk = ~clk;

    step_ctrl #(.DEBOUNCE_CYCLES(16), .RUN_DIV(4), .BURST_W(8)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .step_btn   (step_btn),
        .clk_select (clk_select),
        .burst_len  (burst_len),
        .halt       (halt),
        .cpu_en     (cpu_en),
        .busy       (busy),
        .step_count (step_count)
    );

    step_ctrl #(.DEBOUNCE_CYCLES(16), .RUN_DIV(1), .BURST_W(8)) u_wrap (
        .clk        (clk),
        .rst        (w_rst),
        .step_btn   (1'b0),
        .clk_select (w_sel),
        .burst_len  (8'd0),
        .halt       (1'b0),
        .cpu_en     (w_en),
        .busy       (w_busy),
        .step_count (w_count)
    );

    task automatic clr_mon();
        t = 0; en_cnt = 0; en_first = -1; en_last = -1;
        busy_cnt = 0; busy_bad = 0; gap_min = 1000000; gap_max = 0;
    endtask

    task automatic tick();
        int gap;
        @(negedge clk);
        if (cpu_en === 1'b1) begin
            if (en_cnt == 0) begin
                en_first = t;
            end else begin
                gap = t - en_last;
                if (gap < gap_min) gap_min = gap;
                if (gap > gap_max) gap_max = gap;
            end
            en_last = t;
            en_cnt++;
        end
        if (busy === 1'b1) busy_cnt++;
        if (!clk_select && busy !== cpu_en) busy_bad++;
        t++;
    endtask

    task automatic test_reset();
        rst = 1'b1; w_rst = 1'b1;
        step_btn = 1'b0; clk_select = 1'b0; burst_len = 8'd0; halt = 1'b0; w_sel = 1'b0;
        clr_mon();
        repeat (3) tick();
        rst = 1'b0; w_rst = 1'b0;
        checks++; if (cpu_en !== 1'b0) begin errors++; $display("FAIL reset_cpu_en got=%b exp=0", cpu_en); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (step_count !== 16'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", step_count); end
        repeat (10) tick();
    endtask

    task automatic test_clean_press();
        burst_len = 8'd3;
        clr_mon();
        step_btn = 1'b1;
        repeat (40) tick();
        step_btn = 1'b0;
        repeat (40) tick();
        checks++; if (en_cnt != 3) begin errors++; $display("FAIL press_en_count got=%0d exp=3", en_cnt); end
        checks++; if (en_first != 18) begin errors++; $display("FAIL press_first got=%0d exp=18", en_first); end
        checks++; if (en_last != 20) begin errors++; $display("FAIL press_last got=%0d exp=20", en_last); end
        checks++; if (busy_cnt != 3) begin errors++; $display("FAIL press_busy_count got=%0d exp=3", busy_cnt); end
        checks++; if (busy_bad != 0) begin errors++; $display("FAIL press_busy_align got=%0d exp=0", busy_bad); end
        checks++; if (step_count !== 16'd3) begin errors++; $display("FAIL press_count got=%0d exp=3", step_count); end
    endtask

    task automatic test_bounce();
        burst_len = 8'd0;
        clr_mon();
        for (int p = 0; p < 5; p++) begin
            step_btn = 1'b1; repeat (6) tick();
            step_btn = 1'b0; repeat (3) tick();
        end
        step_btn = 1'b1;
        repeat (30) tick();
        step_btn = 1'b0;
        repeat (40) tick();
        checks++; if (en_cnt != 1) begin errors++; $display("FAIL bounce_en_count got=%0d exp=1", en_cnt); end
        checks++; if (en_first != 63) begin errors++; $display("FAIL bounce_first got=%0d exp=63", en_first); end
        checks++; if (busy_cnt != 1) begin errors++; $display("FAIL bounce_busy got=%0d exp=1", busy_cnt); end
        checks++; if (step_count !== 16'd4) begin errors++; $display("FAIL bounce_count got=%0d exp=4", step_count); end
    endtask

    task automatic test_run();
        clk_select = 1'b1;
        clr_mon();
        repeat (41) tick();
        checks++; if (en_cnt != 10) begin errors++; $display("FAIL run_en_count got=%0d exp=10", en_cnt); end
        checks++; if (en_first != 4) begin errors++; $display("FAIL run_first got=%0d exp=4", en_first); end
        checks++; if (en_last != 40) begin errors++; $display("FAIL run_last got=%0d exp=40", en_last); end
        checks++; if (gap_min != 4 || gap_max != 4) begin
            errors++; $display("FAIL run_spacing got=%0d..%0d exp=4..4", gap_min, gap_max);
        end
        checks++; if (busy_cnt != 0) begin errors++; $display("FAIL run_busy got=%0d exp=0", busy_cnt); end
        // Divider continues: enables land at 3,7,...,39; halt over edges 10..17 drops 11 and 15.
        clr_mon();
        for (int j = 0; j < 40; j++) begin
            halt = (j >= 10 && j < 18);
            tick();
        end
        halt = 1'b0;
        checks++; if (en_cnt != 8) begin errors++; $display("FAIL run_halt_en_count got=%0d exp=8", en_cnt); end
        clk_select = 1'b0;
        repeat (3) tick();
        checks++; if (step_count !== 16'd22) begin errors++; $display("FAIL run_count got=%0d exp=22", step_count); end
        repeat (5) tick();
    endtask

    task automatic test_halt_burst();
        burst_len = 8'd10;
        clr_mon();
        step_btn = 1'b1;
        for (int i = 0; i < 40 && en_cnt < 4; i++) tick();
        checks++; if (en_cnt != 4 || en_last != 21) begin
            errors++; $display("FAIL halt_fourth got=%0d@%0d exp=4@21", en_cnt, en_last);
        end
        halt = 1'b1;
        tick();
        checks++; if (cpu_en !== 1'b0) begin errors++; $display("FAIL halt_cpu_en got=%b exp=0", cpu_en); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL halt_busy got=%b exp=0", busy); end
        repeat (5) tick();
        halt = 1'b0;
        repeat (10) tick();
        step_btn = 1'b0;
        repeat (40) tick();
        checks++; if (en_cnt != 4) begin errors++; $display("FAIL halt_en_total got=%0d exp=4", en_cnt); end
        checks++; if (step_count !== 16'd26) begin errors++; $display("FAIL halt_count got=%0d exp=26", step_count); end
        clr_mon();
        step_btn = 1'b1;
        repeat (40) tick();
        step_btn = 1'b0;
        repeat (40) tick();
        checks++; if (en_cnt != 10 || en_first != 18) begin
            errors++; $display("FAIL halt_reburst got=%0d@%0d exp=10@18", en_cnt, en_first);
        end
        checks++; if (busy_cnt != 10) begin errors++; $display("FAIL halt_reburst_busy got=%0d exp=10", busy_cnt); end
        checks++; if (step_count !== 16'd36) begin errors++; $display("FAIL halt_reburst_count got=%0d exp=36", step_count); end
    endtask

    task automatic test_mode_switch();
        burst_len = 8'd10;
        clr_mon();
        step_btn = 1'b1;
        for (int i = 0; i < 40 && en_cnt < 2; i++) tick();
        clk_select = 1'b1;
        tick();
        checks++; if (cpu_en !== 1'b0) begin errors++; $display("FAIL mode_cpu_en got=%b exp=0", cpu_en); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mode_busy got=%b exp=0", busy); end
        checks++; if (step_count !== 16'd38) begin errors++; $display("FAIL mode_count got=%0d exp=38", step_count); end
        clk_select = 1'b0;
        step_btn = 1'b0;
        repeat (30) tick();
        checks++; if (en_cnt != 2) begin errors++; $display("FAIL mode_no_resume got=%0d exp=2", en_cnt); end
    endtask

    task automatic test_reset_mid_burst();
        burst_len = 8'd10;
        clr_mon();
        step_btn = 1'b1;
        for (int i = 0; i < 40 && en_cnt < 2; i++) tick();
        rst = 1'b1;
        tick();
        checks++; if (cpu_en !== 1'b0) begin errors++; $display("FAIL rst_cpu_en got=%b exp=0", cpu_en); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
        checks++; if (step_count !== 16'd0) begin errors++; $display("FAIL rst_count got=%0d exp=0", step_count); end
        rst = 1'b0;
        repeat (40) tick();
        checks++; if (en_cnt != 2) begin errors++; $display("FAIL rst_held_no_step got=%0d exp=2", en_cnt); end
        step_btn = 1'b0;
        repeat (30) tick();
    endtask

    task automatic test_wrap();
        // After the select edge C: cpu_en from C+1, count after C+k is k-1.
        w_sel = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (w_en !== 1'b1 || w_count !== 16'd1) begin
            errors++; $display("FAIL wrap_start got=%b/%0d exp=1/1", w_en, w_count);
        end
        repeat (65535) @(negedge clk);
        checks++; if (w_count !== 16'h0000) begin errors++; $display("FAIL wrap_zero got=%h exp=0000", w_count); end
        @(negedge clk);
        checks++; if (w_count !== 16'h0001) begin errors++; $display("FAIL wrap_one got=%h exp=0001", w_count); end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_run();
        test_halt_burst();
        test_mode_switch();
        test_reset_mid_burst();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
